// File: rtl/inst_fetch.sv
// inst_fetch: fetch stage assembling 32-bit little-endian instructions from four byte-wide memory reads.
// Defining INST_FETCH_ICACHE_EN adds a direct-mapped instruction cache with a one-cycle LOOKUP state.
module inst_fetch #(
   parameter logic [31:0] RESET_PC       = 32'h0,
   parameter int          ICACHE_ENTRIES = 64
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        stall_in,
   input  logic        jump_in,
   input  logic [31:0] jump_addr_in,
   input  logic        mem_gnt_in,
   input  logic [7:0]  mem_data_in,
   output logic        mem_req_out,
   output logic [31:0] mem_addr_out,
   output logic [31:0] pc_out,
   output logic [31:0] inst_out,
   output logic        inst_valid_out
);

   typedef enum logic [1:0] {
      FETCH  = 2'd0,
      HOLD   = 2'd1,
      LOOKUP = 2'd2
   } state_t;

`ifdef INST_FETCH_ICACHE_EN
   localparam state_t START = LOOKUP;
`else
   localparam state_t START = FETCH;
`endif

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] inst_q, inst_d;
   logic [2:0]  issue_q, issue_d;
   logic [1:0]  rcv_q, rcv_d;
   logic [23:0] byte_buf_q, byte_buf_d;
   logic        pend_q, drop_q;
   logic        req_d;
   logic [31:0] addr_d;
   logic        grant, capture, fill_en;

`ifdef INST_FETCH_ICACHE_EN
   localparam int IDX_W = $clog2(ICACHE_ENTRIES);
   localparam int TAG_W = 30 - IDX_W;

   logic [ICACHE_ENTRIES-1:0] line_valid;
   logic [TAG_W-1:0]          line_tag  [ICACHE_ENTRIES];
   logic [31:0]               line_data [ICACHE_ENTRIES];
   logic [IDX_W-1:0]          idx;
   logic [TAG_W-1:0]          tag;
   logic                      hit;

   assign idx = pc_q[IDX_W+1:2];
   assign tag = pc_q[31:IDX_W+2];
   assign hit = line_valid[idx] && (line_tag[idx] == tag);

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         line_valid <= '0;
      end else if (fill_en) begin
         line_valid[idx] <= 1'b1;
      end
   end

   // NOTE: tag/data storage is deliberately not reset; the valid bits alone decide whether a line is used.
   always_ff @(posedge clk_in) begin
      if (fill_en) begin
         line_tag[idx]  <= tag;
         line_data[idx] <= inst_d;
      end
   end

   logic unused_bits;
   assign unused_bits = ^jump_addr_in[1:0];
`else
   logic unused_bits;
   assign unused_bits = ^{jump_addr_in[1:0], fill_en, ICACHE_ENTRIES};
`endif

   always_comb begin
      // NOTE: every signal written here gets its default first, so no path can infer a latch.
      state_d    = state_q;
      pc_d       = pc_q;
      inst_d     = inst_q;
      issue_d    = issue_q;
      rcv_d      = rcv_q;
      byte_buf_d = byte_buf_q;
      fill_en    = 1'b0;
      grant      = mem_req_out & mem_gnt_in;
      capture    = pend_q & ~drop_q;

      if (jump_in) begin
         // Redirect wins over stall, consumption and any byte capture this cycle.
         pc_d    = {jump_addr_in[31:2], 2'b00};
         issue_d = 3'd0;
         rcv_d   = 2'd0;
         state_d = START;
      end else begin
         case (state_q)
            FETCH: begin
               if (grant) begin
                  issue_d = issue_q + 3'd1;
               end
               if (capture) begin
                  case (rcv_q)
                     2'd0:    byte_buf_d[7:0]   = mem_data_in;
                     2'd1:    byte_buf_d[15:8]  = mem_data_in;
                     2'd2:    byte_buf_d[23:16] = mem_data_in;
                     default: begin
                        inst_d  = {mem_data_in, byte_buf_q};
                        state_d = HOLD;
                        fill_en = 1'b1;
                     end
                  endcase
                  rcv_d = rcv_q + 2'd1;
               end
            end
            HOLD: begin
               if (!stall_in) begin
                  pc_d    = pc_q + 32'd4;
                  issue_d = 3'd0;
                  rcv_d   = 2'd0;
                  state_d = START;
               end
            end
`ifdef INST_FETCH_ICACHE_EN
            LOOKUP: begin
               if (hit) begin
                  inst_d  = line_data[idx];
                  state_d = HOLD;
               end else begin
                  state_d = FETCH;
               end
            end
`endif
            default: state_d = START;
         endcase
      end

      // Request outputs are registered; an ungranted request reproduces the same address next cycle.
      req_d  = (state_d == FETCH) && (issue_d < 3'd4);
      addr_d = req_d ? (pc_d + {29'd0, issue_d}) : 32'd0;
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q      <= START;
         pc_q         <= RESET_PC;
         inst_q       <= '0;
         issue_q      <= '0;
         rcv_q        <= '0;
         byte_buf_q   <= '0;
         pend_q       <= 1'b0;
         drop_q       <= 1'b0;
         mem_req_out  <= 1'b0;
         mem_addr_out <= '0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         inst_q       <= inst_d;
         issue_q      <= issue_d;
         rcv_q        <= rcv_d;
         byte_buf_q   <= byte_buf_d;
         pend_q       <= grant;
         drop_q       <= grant & jump_in;
         mem_req_out  <= req_d;
         mem_addr_out <= addr_d;
      end
   end

   assign pc_out         = pc_q;
   assign inst_out       = inst_q;
   assign inst_valid_out = (state_q == HOLD);

endmodule
